wb_store_queue: RTL and testbench
=================================

# wb_store_queue

Writeback-stage store queue: buffers retired memory-destination writes from writeback and drains them in order into the memory stage's writeback store port (`wb_memdata/wb_memaddr/wb_size/wb_valid/wb_ptcid`, throttled by `wbaq_isfull`). Each cycle it also compares the memory stage's two pending read ranges against every buffered store and raises `fwd_stall` on any byte overlap. This blocks a load from reading the D$ before an older store has drained.

## Interface
- `DEPTH`, 8, number of entries; power of two, ≥2.
- `PTR_W`, 3, log2(DEPTH).
- `clk` in 1: core clock; all state updates on rising edge.
- `clr` in 1: reset; synchronous, active-low.
- `enq_valid` in 1: writeback presents one store this cycle.
- `enq_addr` in 32: store start address.
- `enq_data` in 64: store data, right-aligned.
- `enq_size` in 2: 0=1B, 1=2B, 2=4B, 3=8B.
- `enq_ptcid` in 1: protection-tag id forwarded with the store.
- `enq_ready` out 1: queue can accept; `!full`.
- `wb_valid` out 1: head entry presented to the memory stage.
- `wb_memaddr` out 32, `wb_memdata` out 64, `wb_size` out 2, `wb_ptcid` out 1: head entry fields; all-zero when empty.
- `wbaq_isfull` in 1: memory-stage writeback address queue full; head not accepted.
- `probe_valid` in 1: memory stage has a valid instruction.
- `m1_rd`, `m2_rd` in 1 each: operand 1 / operand 2 is a memory read.
- `mem_addr1`, `mem_addr1_end`, `mem_addr2`, `mem_addr2_end` in 32 each: inclusive byte ranges of the reads.
- `fwd_stall` out 1: overlap with a buffered or enqueuing store.
- `sq_empty` out 1: no entries held.
- `sq_count` out PTR_W+1: occupancy.

## Operation
- Circular buffer of DEPTH entries, each holding {addr, data, size, ptcid}, plus head pointer, tail pointer and count registers.
- Enqueue: fires when `enq_valid && enq_ready`. The entry is written at tail, tail increments, and count increments.
- `enq_valid && !enq_ready` is a writeback protocol violation. The store is dropped, and the assertion checker in the bench flags it.
- Dequeue: fires when `wb_valid && !wbaq_isfull`. Head increments and count decrements.
- Simultaneous enqueue and dequeue: both pointers advance and count is unchanged.
- `enq_ready` is computed from the current count only. When full, an enqueue is refused even if a dequeue fires the same cycle.
- Pointers wrap modulo DEPTH. Count saturates neither way, because the handshake rules prevent overflow and underflow.
- Store range: `[addr, addr + (1<<size) - 1]`, computed in 33 bits. A store crossing 0xFFFF_FFFF covers the carry-out bytes only logically; its overlap test uses the 33-bit end, with no wrap to 0.
- Overlap between store range S and read range R: `S.start <= R.end && R.start <= S.end` (33-bit unsigned compare; R zero-extended).
- `fwd_stall` = `probe_valid` AND (OR over every valid entry and the current enqueuing store, of (`m1_rd` & overlap with range1) OR (`m2_rd` & overlap with range2)).
- An entry dequeuing this cycle still counts for `fwd_stall` this cycle.
- No flush input. Stores enter only after commit and always drain.

## Timing
- Enqueue-to-`wb_valid` latency is one cycle. An enqueue into an empty queue presents the entry on the following cycle; there is no bypass.
- `wb_*` and `sq_empty`/`sq_count` are driven from registers and pointer decode, with no combinational path from `enq_*`.
- `fwd_stall` is combinational from registered state, the probe inputs and `enq_*`.
- Back-to-back drain rate is one store per cycle while `wbaq_isfull`=0.
- The head entry is held stable while `wbaq_isfull`=1.
- Reset (`clr`=0 at an edge): head=tail=count=0, contents cleared. The next cycle shows `wb_valid`=0, `wb_*`=0, `sq_empty`=1, `sq_count`=0, `enq_ready`=1, and `fwd_stall`=0 unless an enqueuing store overlaps.
- Reset mid-drain discards all entries, and enqueue is ignored in the reset cycle.

## Test plan
- Reset then idle -> `sq_empty`=1, `wb_valid`=0, `enq_ready`=1, all `wb_*`=0.
- Enqueue 0x1000/8B/data 0x1122334455667788, `wbaq_isfull`=0 -> next cycle `wb_valid`=1 with those fields; the cycle after that, `sq_empty`=1.
- `wbaq_isfull`=1, enqueue 8 stores -> `enq_ready`=0, `sq_count`=8. Then release -> drains in order at 1/cycle, with `enq_ready`=1 after the first dequeue and a wrapped tail accepting the next store.
- Full queue plus enqueue and dequeue in the same cycle -> enqueue refused, count=7, and the assertion checker fires.
- Buffered 0x2003/2B (bytes 0x2003-0x2004), read 0x2004-0x2007 with `m1_rd`=1 -> `fwd_stall`=1. A read of 0x2005-0x2008 gives `fwd_stall`=0. The same read with `m1_rd`=0 gives 0.
- Empty queue, enqueuing 0x3000/4B while reading range2 0x2FFC-0x3000 with `m2_rd`=1 -> `fwd_stall`=1 in the same cycle.

Source files
------------

// File: rtl/wb_store_queue.sv
// wb_store_queue: writeback-stage store queue.
//
// Buffers retired memory-destination stores and drains them in order into
// the memory stage's writeback store port, one per cycle unless wbaq_isfull
// holds the head. Each cycle the memory stage's two pending read ranges are
// compared against every buffered store and the store currently enqueuing;
// any byte overlap raises fwd_stall so a younger load cannot read the D$
// ahead of an older store.
//
// Ports:
//   clk, clr                 clock, synchronous active-low reset
//   enq_valid/addr/data/size/ptcid, enq_ready   store input from writeback
//   wb_valid/memaddr/memdata/size/ptcid         head entry, zero when empty
//   wbaq_isfull              memory-stage queue full, head not accepted
//   probe_valid, m1_rd, m2_rd, mem_addr{1,2}[_end]  read ranges to check
//   fwd_stall                overlap with a buffered/enqueuing store
//   sq_empty, sq_count       occupancy status
module wb_store_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             enq_valid,
  input  logic [31:0]      enq_addr,
  input  logic [63:0]      enq_data,
  input  logic [1:0]       enq_size,
  input  logic             enq_ptcid,
  output logic             enq_ready,
  output logic             wb_valid,
  output logic [31:0]      wb_memaddr,
  output logic [63:0]      wb_memdata,
  output logic [1:0]       wb_size,
  output logic             wb_ptcid,
  input  logic             wbaq_isfull,
  input  logic             probe_valid,
  input  logic             m1_rd,
  input  logic             m2_rd,
  input  logic [31:0]      mem_addr1,
  input  logic [31:0]      mem_addr1_end,
  input  logic [31:0]      mem_addr2,
  input  logic [31:0]      mem_addr2_end,
  output logic             fwd_stall,
  output logic             sq_empty,
  output logic [PTR_W:0]   sq_count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      q_addr  [DEPTH];
  logic [63:0]      q_data  [DEPTH];
  logic [1:0]       q_size  [DEPTH];
  logic             q_ptcid [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;

  logic             enq_fire;
  logic             deq_fire;
  logic [DEPTH-1:0] entry_valid;

  assign enq_ready = (count != FULL_CNT);
  assign wb_valid  = (count != '0);
  assign sq_empty  = (count == '0);
  assign sq_count  = count;
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_fire  = wb_valid && !wbaq_isfull;

  assign wb_memaddr = wb_valid ? q_addr[head]  : '0;
  assign wb_memdata = wb_valid ? q_data[head]  : '0;
  assign wb_size    = wb_valid ? q_size[head]  : '0;
  assign wb_ptcid   = wb_valid ? q_ptcid[head] : 1'b0;

  always_ff @(posedge clk) begin
    if (!clr) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_addr[i]  <= '0;
        q_data[i]  <= '0;
        q_size[i]  <= '0;
        q_ptcid[i] <= 1'b0;
      end
    end else begin
      if (enq_fire) begin
        q_addr[tail]  <= enq_addr;
        q_data[tail]  <= enq_data;
        q_size[tail]  <= enq_size;
        q_ptcid[tail] <= enq_ptcid;
        tail          <= tail + 1'b1;
      end
      if (deq_fire) begin
        head <= head + 1'b1;
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An entry is live when its distance from head (mod DEPTH) is below count;
  // this also covers the full case where head == tail.
  always_comb begin
    entry_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, PTR_W'(i) - head} < count);
    end
  end

  // Store end is kept in 33 bits so a store crossing the top of the address
  // space never wraps to low addresses.
  function automatic logic store_hits(
    input logic [31:0] s_addr,
    input logic [1:0]  s_size,
    input logic        rd1,
    input logic [31:0] r1_start,
    input logic [31:0] r1_end,
    input logic        rd2,
    input logic [31:0] r2_start,
    input logic [31:0] r2_end
  );
    logic [32:0] s_start;
    logic [32:0] s_end;
    logic        ov1;
    logic        ov2;
    s_start = {1'b0, s_addr};
    s_end   = s_start + (33'd1 << s_size) - 33'd1;
    ov1 = (s_start <= {1'b0, r1_end}) && ({1'b0, r1_start} <= s_end);
    ov2 = (s_start <= {1'b0, r2_end}) && ({1'b0, r2_start} <= s_end);
    return (rd1 && ov1) || (rd2 && ov2);
  endfunction

  always_comb begin
    logic hit;
    hit = enq_valid && store_hits(enq_addr, enq_size, m1_rd, mem_addr1,
                                  mem_addr1_end, m2_rd, mem_addr2, mem_addr2_end);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && store_hits(q_addr[i], q_size[i], m1_rd, mem_addr1,
                                       mem_addr1_end, m2_rd, mem_addr2,
                                       mem_addr2_end)) begin
        hit = 1'b1;
      end
    end
    fwd_stall = probe_valid && hit;
  end

endmodule

// File: tb/tb_wb_store_queue.sv
// Directed bench for wb_store_queue: table of overlap probes plus
// hand-written sequences for reset, latency, full/drain and wrap cases.
module tb_wb_store_queue;
  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             clr;
  logic             enq_valid;
  logic [31:0]      enq_addr;
  logic [63:0]      enq_data;
  logic [1:0]       enq_size;
  logic             enq_ptcid;
  logic             enq_ready;
  logic             wb_valid;
  logic [31:0]      wb_memaddr;
  logic [63:0]      wb_memdata;
  logic [1:0]       wb_size;
  logic             wb_ptcid;
  logic             wbaq_isfull;
  logic             probe_valid;
  logic             m1_rd;
  logic             m2_rd;
  logic [31:0]      mem_addr1;
  logic [31:0]      mem_addr1_end;
  logic [31:0]      mem_addr2;
  logic [31:0]      mem_addr2_end;
  logic             fwd_stall;
  logic             sq_empty;
  logic [PTR_W:0]   sq_count;

  wb_store_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .clr(clr),
    .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_data(enq_data),
    .enq_size(enq_size), .enq_ptcid(enq_ptcid), .enq_ready(enq_ready),
    .wb_valid(wb_valid), .wb_memaddr(wb_memaddr), .wb_memdata(wb_memdata),
    .wb_size(wb_size), .wb_ptcid(wb_ptcid), .wbaq_isfull(wbaq_isfull),
    .probe_valid(probe_valid), .m1_rd(m1_rd), .m2_rd(m2_rd),
    .mem_addr1(mem_addr1), .mem_addr1_end(mem_addr1_end),
    .mem_addr2(mem_addr2), .mem_addr2_end(mem_addr2_end),
    .fwd_stall(fwd_stall), .sq_empty(sq_empty), .sq_count(sq_count)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int viol   = 0;

  // Protocol checker: an enqueue offered while the queue is full.
  always @(posedge clk) begin
    if (clr && enq_valid && !enq_ready) viol++;
  end

  typedef struct packed {
    logic        probe;
    logic        m1;
    logic [31:0] a1;
    logic [31:0] a1e;
    logic        m2;
    logic [31:0] a2;
    logic [31:0] a2e;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [12];

  logic [31:0] exp_a [$];
  logic [63:0] exp_d [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
    #1;
  endtask

  task automatic set_enq(input logic v, input logic [31:0] a, input logic [63:0] d,
                         input logic [1:0] s, input logic p);
    enq_valid = v; enq_addr = a; enq_data = d; enq_size = s; enq_ptcid = p;
  endtask

  task automatic set_probe(input logic p, input logic r1, input logic [31:0] a1,
                           input logic [31:0] a1e, input logic r2,
                           input logic [31:0] a2, input logic [31:0] a2e);
    probe_valid = p; m1_rd = r1; mem_addr1 = a1; mem_addr1_end = a1e;
    m2_rd = r2; mem_addr2 = a2; mem_addr2_end = a2e;
  endtask

  task automatic do_reset;
    clr = 1'b0;
    cyc;
    clr = 1'b1;
  endtask

  task automatic drain_check(input string nm);
    for (int i = 0; i < DEPTH + 1 && exp_a.size() > 0; i++) begin
      chk({nm, "_addr"}, {32'h0, wb_memaddr}, {32'h0, exp_a[0]});
      chk({nm, "_data"}, wb_memdata, exp_d[0]);
      cyc;
      void'(exp_a.pop_front());
      void'(exp_d.pop_front());
    end
    chk({nm, "_empty"}, {63'h0, sq_empty}, 64'd1);
  endtask

  task automatic push_store(input logic [31:0] a, input logic [63:0] d);
    set_enq(1'b1, a, d, 2'd3, 1'b0);
    exp_a.push_back(a);
    exp_d.push_back(d);
    cyc;
  endtask

  initial begin
    // Buffered stores for the table: 0x2003/2B and 0xFFFFFFFE/8B
    // (the latter covers 0xFFFFFFFE..0x1_0000_0005 logically).
    vecs[0]  = '{1'b1, 1'b1, 32'h2004, 32'h2007, 1'b0, 32'h0, 32'h0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 32'h2005, 32'h2008, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h2004, 32'h2007, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h2004, 32'h2007, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2000, 32'h2003, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1000, 32'h2002, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'h2003, 32'h2003, 1'b0, 32'h0, 32'h0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 32'h0, 32'h3, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFD, 1'b0, 32'h0, 32'h0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 32'h2005, 32'h2008, 1'b1, 32'h2004, 32'h2004, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 32'h1000, 32'h3000, 1'b0, 32'h0, 32'h0, 1'b1};

    clr = 1'b0;
    wbaq_isfull = 1'b0;
    set_enq(1'b0, 32'h0, 64'h0, 2'd0, 1'b0);
    set_probe(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;

    // Reset then idle
    do_reset;
    cyc;
    set_probe(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'hFFFF_FFFF);
    #1;
    chk("rst_empty", {63'h0, sq_empty}, 64'd1);
    chk("rst_wb_valid", {63'h0, wb_valid}, 64'd0);
    chk("rst_enq_ready", {63'h0, enq_ready}, 64'd1);
    chk("rst_count", {60'h0, sq_count}, 64'd0);
    chk("rst_memaddr", {32'h0, wb_memaddr}, 64'd0);
    chk("rst_memdata", wb_memdata, 64'd0);
    chk("rst_size_ptcid", {61'h0, wb_size, wb_ptcid}, 64'd0);
    chk("rst_fwd_stall", {63'h0, fwd_stall}, 64'd0);
    set_probe(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Single store: one-cycle latency, no bypass
    set_enq(1'b1, 32'h1000, 64'h1122334455667788, 2'd3, 1'b1);
    #1;
    chk("lat_no_bypass", {63'h0, wb_valid}, 64'd0);
    cyc;
    set_enq(1'b0, 32'h0, 64'h0, 2'd0, 1'b0);
    #1;
    chk("lat_wb_valid", {63'h0, wb_valid}, 64'd1);
    chk("lat_memaddr", {32'h0, wb_memaddr}, 64'h1000);
    chk("lat_memdata", wb_memdata, 64'h1122334455667788);
    chk("lat_size", {62'h0, wb_size}, 64'd3);
    chk("lat_ptcid", {63'h0, wb_ptcid}, 64'd1);
    // Dequeuing entry still stalls a read of its last byte; next byte clear
    set_probe(1'b1, 1'b1, 32'h1007, 32'h1007, 1'b0, 32'h0, 32'h0);
    #1;
    chk("deq_entry_stall", {63'h0, fwd_stall}, 64'd1);
    set_probe(1'b1, 1'b1, 32'h1008, 32'h1010, 1'b0, 32'h0, 32'h0);
    #1;
    chk("deq_entry_past_end", {63'h0, fwd_stall}, 64'd0);
    set_probe(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    cyc;
    chk("lat_drained_empty", {63'h0, sq_empty}, 64'd1);
    chk("lat_drained_memdata", wb_memdata, 64'd0);

    // Fill to 8 while held, then drain in order with a wrapped enqueue
    wbaq_isfull = 1'b1;
    for (int k = 0; k < DEPTH; k++) push_store(32'h4000 + 32'(k * 8), 64'hA0 + 64'(k));
    set_enq(1'b0, 32'h0, 64'h0, 2'd0, 1'b0);
    #1;
    chk("full_count", {60'h0, sq_count}, 64'd8);
    chk("full_enq_ready", {63'h0, enq_ready}, 64'd0);
    cyc;
    chk("hold_addr", {32'h0, wb_memaddr}, {32'h0, exp_a[0]});
    chk("hold_data", wb_memdata, exp_d[0]);
    wbaq_isfull = 1'b0;
    cyc;
    void'(exp_a.pop_front());
    void'(exp_d.pop_front());
    chk("first_deq_ready", {63'h0, enq_ready}, 64'd1);
    chk("first_deq_count", {60'h0, sq_count}, 64'd7);
    chk("wrap_head", {32'h0, wb_memaddr}, {32'h0, exp_a[0]});
    push_store(32'h4040, 64'hA8);
    void'(exp_a.pop_front());
    void'(exp_d.pop_front());
    set_enq(1'b0, 32'h0, 64'h0, 2'd0, 1'b0);
    #1;
    chk("wrap_count", {60'h0, sq_count}, 64'd7);
    drain_check("drain1");

    // Full queue: enqueue refused even though a dequeue fires
    wbaq_isfull = 1'b1;
    for (int k = 0; k < DEPTH; k++) push_store(32'h5000 + 32'(k * 8), 64'hB0 + 64'(k));
    begin
      int v0;
      v0 = viol;
      wbaq_isfull = 1'b0;
      set_enq(1'b1, 32'hDEAD_0000, 64'hDEAD, 2'd3, 1'b0);
      cyc;
      void'(exp_a.pop_front());
      void'(exp_d.pop_front());
      set_enq(1'b0, 32'h0, 64'h0, 2'd0, 1'b0);
      #1;
      chk("refuse_count", {60'h0, sq_count}, 64'd7);
      chk("refuse_checker", 64'(viol), 64'(v0 + 1));
    end
    drain_check("drain2");

    // Overlap table against two held stores
    do_reset;
    wbaq_isfull = 1'b1;
    set_enq(1'b1, 32'h2003, 64'h55, 2'd1, 1'b0);
    cyc;
    set_enq(1'b1, 32'hFFFF_FFFE, 64'h66, 2'd3, 1'b0);
    cyc;
    set_enq(1'b0, 32'h0, 64'h0, 2'd0, 1'b0);
    #1;
    chk("ovl_count", {60'h0, sq_count}, 64'd2);
    for (int i = 0; i < 12; i++) begin
      set_probe(vecs[i].probe, vecs[i].m1, vecs[i].a1, vecs[i].a1e,
                vecs[i].m2, vecs[i].a2, vecs[i].a2e);
      #1;
      chk($sformatf("fwd_vec[%0d]", i), {63'h0, fwd_stall}, {63'h0, vecs[i].exp_stall});
    end
    set_probe(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Empty queue: the enqueuing store alone raises the stall
    wbaq_isfull = 1'b0;
    do_reset;
    wbaq_isfull = 1'b1;
    set_probe(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2FFC, 32'h3000);
    #1;
    chk("enq_ovl_idle", {63'h0, fwd_stall}, 64'd0);
    set_enq(1'b1, 32'h3000, 64'h77, 2'd2, 1'b0);
    #1;
    chk("enq_ovl_stall", {63'h0, fwd_stall}, 64'd1);
    chk("enq_ovl_no_bypass", {63'h0, wb_valid}, 64'd0);
    cyc;
    set_enq(1'b1, 32'h3100, 64'h78, 2'd2, 1'b0);
    cyc;

    // Reset mid-drain with an enqueue offered in the reset cycle
    clr = 1'b0;
    wbaq_isfull = 1'b0;
    set_enq(1'b1, 32'h3000, 64'h79, 2'd2, 1'b0);
    cyc;
    clr = 1'b1;
    set_enq(1'b0, 32'h0, 64'h0, 2'd0, 1'b0);
    #1;
    chk("midrst_count", {60'h0, sq_count}, 64'd0);
    chk("midrst_empty", {63'h0, sq_empty}, 64'd1);
    chk("midrst_wb_valid", {63'h0, wb_valid}, 64'd0);
    chk("midrst_memaddr", {32'h0, wb_memaddr}, 64'd0);
    chk("midrst_enq_ready", {63'h0, enq_ready}, 64'd1);
    chk("midrst_fwd_stall", {63'h0, fwd_stall}, 64'd0);
    set_probe(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

    chk("checker_total", 64'(viol), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
